// File: rtl/fetch_pkg.sv
// Shared constants and encodings for the instruction fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  typedef enum logic [1:0] {StReq, StDrain, StHold, StHalt} fetch_state_e;

  typedef enum logic [1:0] {PcHold, PcIncr, PcRedirect} pc_sel_e;

  // Bubble: NOP with incrPC/err held. Flush: NOP with err cleared (redirect).
  typedef enum logic [2:0] {OutHold, OutMem, OutBuf, OutBubble, OutFlush} out_sel_e;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/dff.sv
// Enabled register with asynchronous active-high reset.
module dff #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= ResetVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_fsm.sv
// Fetch control: state sequencing, memory request and datapath enables.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     stall_in,
  input  logic     redirect,
  input  logic     mem_done,
  input  logic     mem_halt,
  input  logic     buf_halt,
  output logic     mem_rd,
  output logic     in_drain,
  output logic     halted,
  output pc_sel_e  pc_sel,
  output out_sel_e out_sel,
  output logic     buf_load,
  output logic     buf_clear,
  output logic     drain_latch
);

  fetch_state_e state_q, state_d;

  always_comb begin
    state_d     = state_q;
    pc_sel      = PcHold;
    out_sel     = OutHold;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    drain_latch = 1'b0;
    case (state_q)
      StReq: begin
        if (redirect) begin
          pc_sel    = PcRedirect;
          out_sel   = OutFlush;
          buf_clear = 1'b1;
          // The outstanding read must still complete at its original address.
          if (!mem_done) begin
            drain_latch = 1'b1;
            state_d     = StDrain;
          end
        end else if (mem_done) begin
          pc_sel = PcIncr;
          if (stall_in) begin
            buf_load = 1'b1;
            state_d  = StHold;
          end else begin
            out_sel = OutMem;
            if (mem_halt) state_d = StHalt;
          end
        end else if (!stall_in) begin
          out_sel = OutBubble;
        end
      end
      StDrain: begin
        if (redirect) pc_sel = PcRedirect;
        if (mem_done) state_d = StReq;
      end
      StHold: begin
        if (redirect) begin
          pc_sel    = PcRedirect;
          out_sel   = OutFlush;
          buf_clear = 1'b1;
          state_d   = StReq;
        end else if (!stall_in) begin
          out_sel = OutBuf;
          state_d = buf_halt ? StHalt : StReq;
        end
      end
      StHalt: begin
        if (redirect) begin
          pc_sel    = PcRedirect;
          out_sel   = OutFlush;
          buf_clear = 1'b1;
          state_d   = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StReq;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == StHalt);
    end
  end

  assign mem_rd   = (state_q == StReq || state_q == StDrain) && !rst;
  assign in_drain = (state_q == StDrain);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC, skid buffer and fetch/decode pipeline register.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic [15:0] instruction_out,
  output logic [15:0] incrPC_out,
  output logic        err_out,
  output logic        halted
);

  pc_sel_e  pc_sel;
  out_sel_e out_sel;
  logic     buf_load, buf_clear, drain_latch, in_drain;

  logic [15:0] pc_q, pc_d, pc_plus2;
  logic [15:0] buf_instr_q, buf_incr_q;
  logic        buf_err_q, buf_valid_q;
  logic [15:0] drain_addr_q;
  logic [15:0] instr_d, incr_d;
  logic        err_d;
  logic        instr_en, incr_en, err_en, buf_valid_en;

  fetch_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .mem_done    (mem_done),
    .mem_halt    (is_halt(mem_data)),
    .buf_halt    (buf_valid_q && is_halt(buf_instr_q)),
    .mem_rd      (mem_rd),
    .in_drain    (in_drain),
    .halted      (halted),
    .pc_sel      (pc_sel),
    .out_sel     (out_sel),
    .buf_load    (buf_load),
    .buf_clear   (buf_clear),
    .drain_latch (drain_latch)
  );

  // 16-bit wraparound is intended: FFFE + 2 = 0000.
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PcIncr:     pc_d = pc_plus2;
      PcRedirect: pc_d = redirect_pc;
      default:    pc_d = pc_q;
    endcase
  end

  always_comb begin
    instr_d = instruction_out;
    incr_d  = incrPC_out;
    err_d   = err_out;
    case (out_sel)
      OutMem: begin
        instr_d = mem_data;
        incr_d  = pc_plus2;
        err_d   = pc_q[0];
      end
      OutBuf: begin
        instr_d = buf_instr_q;
        incr_d  = buf_incr_q;
        err_d   = buf_err_q;
      end
      OutBubble: instr_d = NOP_INSTR;
      OutFlush: begin
        instr_d = NOP_INSTR;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign instr_en     = (out_sel != OutHold);
  assign incr_en      = (out_sel == OutMem) || (out_sel == OutBuf);
  assign err_en       = (out_sel == OutMem) || (out_sel == OutBuf) || (out_sel == OutFlush);
  assign buf_valid_en = buf_load || buf_clear || (out_sel == OutBuf);

  dff #(.Width(16), .ResetVal(RESET_PC)) u_pc (
    .clk (clk), .rst (rst), .en (pc_sel != PcHold), .d (pc_d), .q (pc_q)
  );

  dff #(.Width(16), .ResetVal(NOP_INSTR)) u_instr (
    .clk (clk), .rst (rst), .en (instr_en), .d (instr_d), .q (instruction_out)
  );

  dff #(.Width(16), .ResetVal(16'h0000)) u_incr (
    .clk (clk), .rst (rst), .en (incr_en), .d (incr_d), .q (incrPC_out)
  );

  dff #(.Width(1), .ResetVal(1'b0)) u_err (
    .clk (clk), .rst (rst), .en (err_en), .d (err_d), .q (err_out)
  );

  dff #(.Width(16), .ResetVal(16'h0000)) u_buf_instr (
    .clk (clk), .rst (rst), .en (buf_load), .d (mem_data), .q (buf_instr_q)
  );

  dff #(.Width(16), .ResetVal(16'h0000)) u_buf_incr (
    .clk (clk), .rst (rst), .en (buf_load), .d (pc_plus2), .q (buf_incr_q)
  );

  dff #(.Width(1), .ResetVal(1'b0)) u_buf_err (
    .clk (clk), .rst (rst), .en (buf_load), .d (pc_q[0]), .q (buf_err_q)
  );

  dff #(.Width(1), .ResetVal(1'b0)) u_buf_valid (
    .clk (clk), .rst (rst), .en (buf_valid_en), .d (buf_load), .q (buf_valid_q)
  );

  dff #(.Width(16), .ResetVal(16'h0000)) u_drain_addr (
    .clk (clk), .rst (rst), .en (drain_latch), .d (pc_q), .q (drain_addr_q)
  );

  assign mem_addr = in_drain ? drain_addr_q : pc_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, then random traffic against a reference model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, redirect, mem_done, mem_rd, err_out, halted;
  logic [15:0] redirect_pc, mem_addr, mem_data, instruction_out, incrPC_out;

  int checks = 0;
  int errors = 0;

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_done        (mem_done),
    .mem_data        (mem_data),
    .instruction_out (instruction_out),
    .incrPC_out      (incrPC_out),
    .err_out         (err_out),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        done;
    logic [15:0] data;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] incr;
    logic        err;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic [15:0] rpc, input logic d,
                     input logic [15:0] data, input logic rd, input logic [15:0] addr,
                     input logic [15:0] instr, input logic [15:0] incr, input logic err,
                     input logic hlt);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rpc; v.done = d; v.data = data;
    v.rd = rd; v.addr = addr; v.instr = instr; v.incr = incr; v.err = err; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] m_pc, m_instr, m_incr, m_drain_addr;
  logic        m_err, m_halted, m_draining;
  logic [32:0] m_skid[$];

  function automatic logic halt_word(input logic [15:0] w);
    return (w >> 11) == 16'd0;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0800; m_incr = 16'h0000; m_err = 1'b0;
    m_halted = 1'b0; m_draining = 1'b0; m_drain_addr = 16'h0000;
    m_skid.delete();
  endtask

  function automatic logic model_fetching();
    return !m_halted && m_skid.size() == 0 && !m_draining;
  endfunction

  task automatic model_step(input logic s, input logic r, input logic [15:0] rpc,
                            input logic d, input logic [15:0] data);
    logic [32:0] e;
    if (r) begin
      if (m_draining) begin
        m_pc = rpc;
        if (d) m_draining = 1'b0;
      end else begin
        if (model_fetching() && !d) begin
          m_draining   = 1'b1;
          m_drain_addr = m_pc;
        end
        m_pc = rpc; m_instr = 16'h0800; m_err = 1'b0; m_halted = 1'b0;
        m_skid.delete();
      end
    end else if (m_draining) begin
      if (d) m_draining = 1'b0;
    end else if (m_halted) begin
    end else if (m_skid.size() != 0) begin
      if (!s) begin
        e = m_skid.pop_front();
        m_instr = e[32:17]; m_incr = e[16:1]; m_err = e[0];
        m_halted = halt_word(m_instr);
      end
    end else if (d) begin
      if (s) begin
        m_skid.push_back({data, 16'(m_pc + 16'd2), m_pc[0]});
      end else begin
        m_instr = data; m_incr = 16'(m_pc + 16'd2); m_err = m_pc[0];
        m_halted = halt_word(data);
      end
      m_pc = 16'(m_pc + 16'd2);
    end else if (!s) begin
      m_instr = 16'h0800;
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A3C;
  endfunction

  initial begin
    int lat;
    rst = 1'b1; stall_in = 0; redirect = 0; redirect_pc = 0; mem_done = 0; mem_data = 0;

    // Directed table: stall, redir, rpc, done, data | rd, addr | instr, incr, err, halted
    add(0, 0, 16'h0, 1, 16'h4000, 1, 16'h0000, 16'h4000, 16'h0002, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4001, 1, 16'h0002, 16'h4001, 16'h0004, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4002, 1, 16'h0004, 16'h4002, 16'h0006, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4003, 1, 16'h0006, 16'h4003, 16'h0008, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0008, 16'h0800, 16'h0008, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4100, 1, 16'h0008, 16'h4100, 16'h000A, 0, 0);
    add(1, 0, 16'h0, 0, 16'h0000, 1, 16'h000A, 16'h4100, 16'h000A, 0, 0);
    add(1, 0, 16'h0, 1, 16'h4200, 1, 16'h000A, 16'h4100, 16'h000A, 0, 0);
    add(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h4100, 16'h000A, 0, 0);
    add(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h4100, 16'h000A, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h4200, 16'h000C, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h000C, 16'h0800, 16'h000C, 0, 0);
    add(0, 1, 16'h0100, 0, 16'h0000, 1, 16'h000C, 16'h0800, 16'h000C, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h000C, 16'h0800, 16'h000C, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4300, 1, 16'h000C, 16'h0800, 16'h000C, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4400, 1, 16'h0100, 16'h4400, 16'h0102, 0, 0);
    add(0, 0, 16'h0, 1, 16'h0000, 1, 16'h0102, 16'h0000, 16'h0104, 0, 1);
    add(0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0104, 0, 1);
    add(0, 1, 16'h0020, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0104, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4500, 1, 16'h0020, 16'h4500, 16'h0022, 0, 0);
    add(0, 1, 16'h0011, 0, 16'h0000, 1, 16'h0022, 16'h0800, 16'h0022, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4555, 1, 16'h0022, 16'h0800, 16'h0022, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4600, 1, 16'h0011, 16'h4600, 16'h0013, 1, 0);
    add(0, 0, 16'h0, 1, 16'h4700, 1, 16'h0013, 16'h4700, 16'h0015, 1, 0);
    add(0, 1, 16'h0030, 1, 16'h4777, 1, 16'h0015, 16'h0800, 16'h0015, 0, 0);
    add(0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'h0030, 16'h0800, 16'h0015, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4888, 1, 16'h0030, 16'h0800, 16'h0015, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4800, 1, 16'hFFFE, 16'h4800, 16'h0000, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4900, 1, 16'h0000, 16'h4900, 16'h0002, 0, 0);
    add(1, 0, 16'h0, 1, 16'h4A00, 1, 16'h0002, 16'h4900, 16'h0002, 0, 0);
    add(1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0002, 0, 0);
    add(0, 0, 16'h0, 1, 16'h4B00, 1, 16'h0040, 16'h4B00, 16'h0042, 0, 0);
    add(1, 0, 16'h0, 1, 16'h0000, 1, 16'h0042, 16'h4B00, 16'h0042, 0, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0044, 0, 1);
    add(0, 1, 16'h0050, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0044, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset instr", instruction_out, 16'h0800);
    chk("reset incr", incrPC_out, 16'h0000);
    chk("reset err", {15'd0, err_out}, 16'd0);
    chk("reset halted", {15'd0, halted}, 16'd0);
    chk("reset mem_rd", {15'd0, mem_rd}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      stall_in = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      mem_done = vecs[i].done; mem_data = vecs[i].data;
      #1;
      chk($sformatf("v%0d mem_rd", i), {15'd0, mem_rd}, {15'd0, vecs[i].rd});
      if (vecs[i].rd) chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d instr", i), instruction_out, vecs[i].instr);
      chk($sformatf("v%0d incr", i), incrPC_out, vecs[i].incr);
      chk($sformatf("v%0d err", i), {15'd0, err_out}, {15'd0, vecs[i].err});
      chk($sformatf("v%0d halted", i), {15'd0, halted}, {15'd0, vecs[i].hlt});
      @(negedge clk);
    end

    // Asynchronous reset while a request is outstanding
    stall_in = 0; redirect = 0; mem_done = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("async rst instr", instruction_out, 16'h0800);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    lat = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(599) == 0) begin
        rst = 1'b1; mem_done = 0; redirect = 0;
        #1;
        chk("rand rst mem_rd", {15'd0, mem_rd}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        lat = 0;
      end
      stall_in    = ($urandom_range(3) == 0);
      redirect    = ($urandom_range(11) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(3) != 0) redirect_pc[0] = 1'b0;
      mem_done = 1'b0;
      mem_data = 16'($urandom);
      if (mem_rd) begin
        if (lat == 0) begin
          mem_done = 1'b1;
          mem_data = mem_word(mem_addr);
          lat = $urandom_range(2);
        end else begin
          lat--;
        end
      end
      #1;
      chk("rand mem_rd", {15'd0, mem_rd}, {15'd0, !m_halted && m_skid.size() == 0});
      if (!m_halted && m_skid.size() == 0)
        chk("rand mem_addr", mem_addr, m_draining ? m_drain_addr : m_pc);
      model_step(stall_in, redirect, redirect_pc, mem_done, mem_data);
      @(posedge clk);
      #1;
      chk("rand instr", instruction_out, m_instr);
      chk("rand incr", incrPC_out, m_incr);
      chk("rand err", {15'd0, err_out}, {15'd0, m_err});
      chk("rand halted", {15'd0, halted}, {15'd0, m_halted});
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage: owns the PC, issues reads to a variable-latency instruction memory, and drives the fetch/decode pipeline register (instruction, incremented PC, error) consumed directly by the decode stage. Handles decode-side stall (hazard hold), execute-side redirect (taken branch/jump flush), and HALT. It inserts NOP bubbles (16'h0800) whenever no valid instruction is available.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- stall_in  in  1  decode hazard stall; hold pipeline register contents
- redirect  in  1  taken branch/jump from execute; flush and refetch
- redirect_pc  in  16  target PC, valid when redirect=1
- mem_rd  out  1  instruction read request
- mem_addr  out  16  read address (current PC)
- mem_done  in  1  read data valid this cycle (may coincide with first mem_rd cycle)
- mem_data  in  16  instruction word, valid when mem_done=1
- instruction_out  out  16  registered instruction to decode
- incrPC_out  out  16  registered PC+2 of that instruction
- err_out  out  1  registered: instruction was fetched from an odd address
- halted  out  1  fetch has stopped after delivering HALT

## Operation
- States: REQ, DRAIN, HOLD, HALT. Reset state REQ.
- mem_rd = (state==REQ or DRAIN) and not rst. mem_addr = PC in REQ; the latched old address in DRAIN. Address held constant until mem_done.
- REQ, mem_done=1, no redirect, stall_in=0: instruction_out<=mem_data, incrPC_out<=PC+2, err_out<=PC[0], PC<=PC+2. Stay REQ, or go HALT if mem_data[15:11]==5'b00000.
- REQ, mem_done=1, stall_in=1: outputs hold; word, PC+2 and err go to skid buffer; PC<=PC+2; go HOLD.
- REQ, mem_done=0, stall_in=0: instruction_out<=NOP, incrPC_out and err_out hold. If stall_in=1, all outputs hold.
- HOLD: mem_rd=0. When stall_in falls, output registers load from the buffer. Next state is REQ, or HALT if the buffered word is HALT.
- HALT: mem_rd=0, PC holds, halted=1. Exit only on redirect or rst.
- Redirect has priority over stall and over mem_done in every state:
  - PC<=redirect_pc, instruction_out<=NOP, err_out<=0, skid buffer cleared.
  - From REQ with mem_done=0: latch old address, go DRAIN.
  - Otherwise go REQ.
- DRAIN: keep the old request until mem_done, discard the data, go REQ. Output stays NOP. A second redirect in DRAIN only updates PC.
- PC arithmetic: 16-bit modulo; 16'hFFFE+2 = 16'h0000, no error.
- An odd PC is still fetched. err_out marks only the word fetched from that address.

## Timing
- Reset values: PC=RESET_PC, instruction_out=16'h0800, incrPC_out=0, err_out=0, halted=0, buffer empty.
- Latency: mem_done at edge N puts the instruction on instruction_out after edge N. With zero-wait memory, one instruction per cycle.
- Redirect at edge N: NOP on instruction_out after N. First target request in cycle N+1 from REQ, or after mem_done from DRAIN.
- Stall: instruction_out is stable for every cycle stall_in=1, unless a redirect occurs. At most one word is buffered; no request is issued while HOLD.
- Reset asserted mid-request or mid-DRAIN: state returns to REQ immediately. Any in-flight mem_done after reset release is the memory's responsibility (memory is reset by the same rst).

## Structure
- Shared package/include: NOP_INSTR=16'h0800, HALT_OPCODE=5'b00000, state encodings.
- Sub-module fetch_fsm: next-state logic, mem_rd and load/hold/flush enables.
- The top level holds the PC, skid buffer and output registers, built from the codebase dff cell with async reset.

## Test plan
- Zero-wait memory returning 0x4000..0x4003 sequentially from RESET_PC=0 -> instruction_out follows one per cycle; incrPC_out = 2, 4, 6, 8.
- mem_done delayed 3 cycles per fetch -> 3 NOPs (16'h0800) between real instructions; PC advances only on done.
- stall_in high 4 cycles with mem_done arriving during the stall -> instruction_out unchanged; mem_rd low in HOLD; buffered word appears on the first cycle after stall_in falls.
- redirect to 16'h0100 while a fetch is outstanding -> NOP out; stale data discarded; next mem_addr=16'h0100 after DRAIN completes.
- Fetch 16'h0000 (HALT) -> HALT delivered, halted=1, mem_rd=0; redirect to 16'h0020 -> fetching resumes at 16'h0020, halted=0.
- redirect_pc=16'h0011 -> the word fetched there has err_out=1 and incrPC_out=16'h0013; the following word has err_out=1 again (PC stays odd).
